// File: rtl/udp_rx_payload_reader.sv
// Reads each newly validated UDP payload out of the receive RAM and streams it as valid/ready bytes.
// Define UDP_RD_DROP_CNT_EN to add the drop_cnt port counting starts that arrive while busy.
module udp_rx_payload_reader #(
    parameter int ADDR_W    = 11,
    parameter int RAM_DEPTH = 2048,
    parameter int HDR_LEN   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              udp_rec_data_valid,
    input  logic [15:0]       udp_rec_data_length,
    output logic [ADDR_W-1:0] udp_rec_ram_read_addr,
    input  logic [7:0]        udp_rec_ram_rdata,
    output logic [7:0]        m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              frame_done
`ifdef UDP_RD_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);
    localparam int LEN_W = ADDR_W + 1;
    localparam logic [15:0]      HDR_LEN16 = 16'(HDR_LEN);
    localparam logic [15:0]      DEPTH16   = 16'(RAM_DEPTH);
    localparam logic [LEN_W-1:0] DEPTH_L   = LEN_W'(RAM_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic              valid_prev_q, valid_prev_d;
    logic [LEN_W-1:0]  payload_len_q, payload_len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic [1:0][7:0]   fifo_data_q, fifo_data_d;
    logic [1:0]        fifo_last_q, fifo_last_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    logic              start;
    logic [15:0]       len_diff;
    logic [LEN_W-1:0]  new_len;
    logic              push, pop, credit, issue, is_last_addr, drained;
    logic [2:0]        occupancy;

    always_comb begin
        start    = udp_rec_data_valid && !valid_prev_q;
        len_diff = udp_rec_data_length - HDR_LEN16;
        if (udp_rec_data_length <= HDR_LEN16) begin
            new_len = '0;
        end else if (len_diff > DEPTH16) begin
            new_len = DEPTH_L;
        end else begin
            new_len = len_diff[LEN_W-1:0];
        end

        push = inflight_q;
        pop  = (count_q != 2'd0) && m_ready;
        // A pop this cycle frees a slot, which keeps one byte per clock with m_ready high.
        occupancy    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        credit       = occupancy < 3'd2;
        is_last_addr = ({1'b0, addr_q} == payload_len_q - LEN_W'(1));
        issue        = (state_q == READ) && credit;
        drained      = !inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop));
    end

    always_comb begin
        state_d         = state_q;
        valid_prev_d    = udp_rec_data_valid;
        payload_len_d   = payload_len_q;
        addr_d          = addr_q;
        inflight_d      = issue;
        inflight_last_d = issue && is_last_addr;
        case (state_q)
            IDLE: begin
                if (start) begin
                    payload_len_d = new_len;
                    addr_d        = '0;
                    // Empty frames pass through DRAIN so frame_done keeps a fixed offset from start.
                    state_d       = (new_len != '0) ? READ : DRAIN;
                end
            end
            READ: begin
                if (issue) begin
                    if (is_last_addr) begin
                        state_d = DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (drained) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = udp_rec_ram_rdata;
            fifo_last_d[wr_ptr_q] = inflight_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            valid_prev_q    <= 1'b0;
            payload_len_q   <= '0;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_data_q     <= '0;
            fifo_last_q     <= '0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
        end else begin
            state_q         <= state_d;
            valid_prev_q    <= valid_prev_d;
            payload_len_q   <= payload_len_d;
            addr_q          <= addr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            fifo_data_q     <= fifo_data_d;
            fifo_last_q     <= fifo_last_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
        end
    end

`ifdef UDP_RD_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (start && (state_q != IDLE) && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign udp_rec_ram_read_addr = addr_q;
    assign m_valid               = (count_q != 2'd0);
    assign m_data                = fifo_data_q[rd_ptr_q];
    assign m_last                = fifo_last_q[rd_ptr_q];
    assign busy                  = (state_q != IDLE);
    assign frame_done            = (state_q == DONE);

endmodule

// File: tb/tb_udp_rx_payload_reader.sv
// Directed bench for udp_rx_payload_reader: a RAM model with a known byte pattern and per-scenario tasks.
module tb_udp_rx_payload_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        udp_rec_data_valid = 1'b0;
    logic [15:0] udp_rec_data_length = 16'd0;
    logic [10:0] udp_rec_ram_read_addr;
    logic [7:0]  udp_rec_ram_rdata = 8'd0;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready = 1'b0;
    logic        busy;
    logic        frame_done;
`ifdef UDP_RD_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    udp_rx_payload_reader dut (
        .clk                   (clk),
        .rst                   (rst),
        .udp_rec_data_valid    (udp_rec_data_valid),
        .udp_rec_data_length   (udp_rec_data_length),
        .udp_rec_ram_read_addr (udp_rec_ram_read_addr),
        .udp_rec_ram_rdata     (udp_rec_ram_rdata),
        .m_data                (m_data),
        .m_valid               (m_valid),
        .m_last                (m_last),
        .m_ready               (m_ready),
        .busy                  (busy),
        .frame_done            (frame_done)
`ifdef UDP_RD_DROP_CNT_EN
        ,
        .drop_cnt              (drop_cnt)
`endif
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] exp_byte(input int i);
        return 8'((i * 37 + 11) ^ (i >> 8));
    endfunction

    // RAM model: one-cycle registered read
    logic [7:0] ram [0:2047];
    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = exp_byte(i);
    end
    always @(posedge clk) udp_rec_ram_rdata <= ram[udp_rec_ram_read_addr];

    // Monitor, sampled on the falling edge
    logic [7:0]  got_data[$];
    logic        got_last[$];
    int          got_cyc[$];
    int          done_cyc[$];
    logic [10:0] addr_trace[$];
    logic        busy_trace[$];
    logic [7:0]  exp_q[$];
    int          hold_err = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'd0;
    logic        prev_last = 1'b0;
    int          start_cyc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                got_last.push_back(m_last);
                got_cyc.push_back(cyc);
            end
            if (frame_done) done_cyc.push_back(cyc);
            if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) hold_err++;
        end
        prev_stall = m_valid && !m_ready && !rst;
        prev_data  = m_data;
        prev_last  = m_last;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_data.delete();
        got_last.delete();
        got_cyc.delete();
        done_cyc.delete();
        addr_trace.delete();
        busy_trace.delete();
        exp_q.delete();
        hold_err = 0;
    endtask

    task automatic run_frame(input logic [15:0] len, input logic [3:0] rdy_pat, input int budget);
        int k;
        clear_mon();
        udp_rec_data_length = len;
        udp_rec_data_valid  = 1'b1;
        m_ready             = rdy_pat[0];
        start_cyc           = cyc;
        k = 0;
        while (done_cyc.size() == 0 && k < budget) begin
            tick();
            k++;
            m_ready = rdy_pat[k % 4];
            addr_trace.push_back(udp_rec_ram_read_addr);
            busy_trace.push_back(busy);
        end
        udp_rec_data_valid = 1'b0;
        m_ready = 1'b1;
        repeat (3) tick();
    endtask

    // Tests
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({udp_rec_ram_read_addr, m_data, m_valid, m_last, busy, frame_done} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs got %0h required 0",
                     {udp_rec_ram_read_addr, m_data, m_valid, m_last, busy, frame_done});
        end
`ifdef UDP_RD_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_drop_cnt got %0d required 0", drop_cnt);
        end
`endif
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_len16();
        run_frame(16'd16, 4'b1111, 40);
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (addr_trace[j] !== 11'(j)) begin
                errors++;
                $display("FAIL len16_addr cycle N+%0d got %0d required %0d", j + 1, addr_trace[j], j);
            end
        end
        checks++;
        if (busy_trace[0] !== 1'b1) begin
            errors++;
            $display("FAIL len16_busy got %0b required 1", busy_trace[0]);
        end
        checks++;
        if (got_data.size() != 8) begin
            errors++;
            $display("FAIL len16_count got %0d required 8", got_data.size());
        end
        for (int i = 0; i < 8; i++) exp_q.push_back(exp_byte(i));
        for (int i = 0; i < 8 && i < got_data.size(); i++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if ({got_last[i], got_data[i]} !== {(i == 7), e} || got_cyc[i] != start_cyc + 3 + i) begin
                errors++;
                $display("FAIL len16_byte%0d got last=%0b data=%0h cyc=%0d required last=%0b data=%0h cyc=%0d",
                         i, got_last[i], got_data[i], got_cyc[i] - start_cyc, (i == 7), e, 3 + i);
            end
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != start_cyc + 11) begin
            errors++;
            $display("FAIL len16_done got count=%0d at N+%0d required count=1 at N+11",
                     done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] - start_cyc : -1);
        end
    endtask

    task automatic test_zero_len();
        logic [15:0] lens [2];
        lens[0] = 16'd8;
        lens[1] = 16'd5;
        for (int t = 0; t < 2; t++) begin
            run_frame(lens[t], 4'b1111, 10);
            checks++;
            if (got_data.size() != 0) begin
                errors++;
                $display("FAIL zero_len%0d_bytes got %0d required 0", lens[t], got_data.size());
            end
            checks++;
            if (done_cyc.size() != 1 || done_cyc[0] != start_cyc + 2) begin
                errors++;
                $display("FAIL zero_len%0d_done got count=%0d at N+%0d required count=1 at N+2", lens[t],
                         done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] - start_cyc : -1);
            end
        end
    endtask

    task automatic test_stall();
        run_frame(16'd13, 4'b1001, 60);
        checks++;
        if (got_data.size() != 5 || done_cyc.size() != 1) begin
            errors++;
            $display("FAIL stall_count got bytes=%0d done=%0d required bytes=5 done=1",
                     got_data.size(), done_cyc.size());
        end
        for (int i = 0; i < 5; i++) exp_q.push_back(exp_byte(i));
        for (int i = 0; i < 5 && i < got_data.size(); i++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if ({got_last[i], got_data[i]} !== {(i == 4), e}) begin
                errors++;
                $display("FAIL stall_byte%0d got last=%0b data=%0h required last=%0b data=%0h",
                         i, got_last[i], got_data[i], (i == 4), e);
            end
        end
        checks++;
        if (hold_err != 0) begin
            errors++;
            $display("FAIL stall_hold got %0d changes while stalled required 0", hold_err);
        end
    endtask

    task automatic test_ignored_start();
        int k;
        clear_mon();
        udp_rec_data_length = 16'd20;
        udp_rec_data_valid  = 1'b1;
        m_ready             = 1'b1;
        start_cyc           = cyc;
        k = 0;
        while (done_cyc.size() == 0 && k < 60) begin
            tick();
            k++;
            if (k == 3) udp_rec_data_valid = 1'b0;
            if (k == 5) begin
                udp_rec_data_length = 16'd40;
                udp_rec_data_valid  = 1'b1;
            end
        end
        checks++;
        if (got_data.size() != 12 || done_cyc.size() != 1 || done_cyc[0] != start_cyc + 15) begin
            errors++;
            $display("FAIL ignored_frame got bytes=%0d done=%0d at N+%0d required bytes=12 done=1 at N+15",
                     got_data.size(), done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] - start_cyc : -1);
        end
        for (int i = 0; i < 12; i++) exp_q.push_back(exp_byte(i));
        for (int i = 0; i < 12 && i < got_data.size(); i++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if ({got_last[i], got_data[i]} !== {(i == 11), e}) begin
                errors++;
                $display("FAIL ignored_byte%0d got last=%0b data=%0h required last=%0b data=%0h",
                         i, got_last[i], got_data[i], (i == 11), e);
            end
        end
`ifdef UDP_RD_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL ignored_drop_cnt got %0d required 1", drop_cnt);
        end
`endif
        // valid is still held high: no new frame may start without a fresh rising edge
        repeat (4) tick();
        checks++;
        if (busy !== 1'b0 || got_data.size() != 12) begin
            errors++;
            $display("FAIL held_valid_restart got busy=%0b bytes=%0d required busy=0 bytes=12",
                     busy, got_data.size());
        end
        udp_rec_data_valid = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        clear_mon();
        udp_rec_data_length = 16'd20;
        udp_rec_data_valid  = 1'b1;
        m_ready             = 1'b1;
        start_cyc           = cyc;
        repeat (6) tick();
        checks++;
        if (m_valid !== 1'b1 || m_data !== exp_byte(3)) begin
            errors++;
            $display("FAIL rst_mid_byte3 got valid=%0b data=%0h required valid=1 data=%0h",
                     m_valid, m_data, exp_byte(3));
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({udp_rec_ram_read_addr, m_data, m_valid, m_last, busy, frame_done} !== 23'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs got %0h required 0",
                     {udp_rec_ram_read_addr, m_data, m_valid, m_last, busy, frame_done});
        end
`ifdef UDP_RD_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_drop_cnt got %0d required 0", drop_cnt);
        end
`endif
        rst = 1'b0;
        udp_rec_data_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (done_cyc.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_no_done got %0d pulses required 0", done_cyc.size());
        end
        run_frame(16'd12, 4'b1111, 40);
        checks++;
        if (got_data.size() != 4 || done_cyc.size() != 1 || done_cyc[0] != start_cyc + 7) begin
            errors++;
            $display("FAIL post_rst_frame got bytes=%0d done=%0d at N+%0d required bytes=4 done=1 at N+7",
                     got_data.size(), done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] - start_cyc : -1);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_byte(i));
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if ({got_last[i], got_data[i]} !== {(i == 3), e}) begin
                errors++;
                $display("FAIL post_rst_byte%0d got last=%0b data=%0h required last=%0b data=%0h",
                         i, got_last[i], got_data[i], (i == 3), e);
            end
        end
    endtask

    task automatic test_clamp();
        int          bad;
        int          last_cnt;
        logic [10:0] max_addr;
        run_frame(16'd3000, 4'b1111, 2200);
        checks++;
        if (got_data.size() != 2048 || done_cyc.size() != 1 || done_cyc[0] != start_cyc + 3 + 2048) begin
            errors++;
            $display("FAIL clamp_frame got bytes=%0d done=%0d at N+%0d required bytes=2048 done=1 at N+2051",
                     got_data.size(), done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] - start_cyc : -1);
        end
        for (int i = 0; i < 2048; i++) exp_q.push_back(exp_byte(i));
        bad = 0;
        last_cnt = 0;
        for (int i = 0; i < got_data.size(); i++) begin
            logic [7:0] e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'd0;
            if (got_data[i] !== e) bad++;
            if (got_last[i] === 1'b1) last_cnt++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clamp_data got %0d wrong bytes required 0", bad);
        end
        checks++;
        if (last_cnt != 1 || got_last.size() != 2048 || got_last[2047] !== 1'b1) begin
            errors++;
            $display("FAIL clamp_last got %0d last flags required exactly one on byte 2047", last_cnt);
        end
        max_addr = 11'd0;
        foreach (addr_trace[j]) if (addr_trace[j] > max_addr) max_addr = addr_trace[j];
        checks++;
        if (max_addr !== 11'd2047) begin
            errors++;
            $display("FAIL clamp_max_addr got %0d required 2047", max_addr);
        end
    endtask

    initial begin
        test_reset();
        test_len16();
        test_zero_len();
        test_stall();
        test_ignored_start();
        test_reset_mid();
        test_clamp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
